gcd_param: RTL and testbench
============================

GCD_PARAM -- requirements
Module: gcd_param

Interface
REQ-001 Parameter WIDTH, default 8, is the operand and result width in bits; legal values are 2 to 32.
REQ-002 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 Port reset, input, 1 bit: reset is synchronous and active-high.
REQ-004 Port a, input, WIDTH bits: first unsigned operand, sampled when ld=1.
REQ-005 Port b, input, WIDTH bits: second unsigned operand, sampled when ld=1.
REQ-006 Port ld, input, 1 bit: load request, a single-cycle pulse per operand pair.
REQ-007 Port q, output, WIDTH bits: last GCD result, held until the next completion.
REQ-008 Port rdy, output, 1 bit: one-cycle pulse, high in the cycle after a completion edge.
REQ-009 Port busy, output, 1 bit: high when the state is CALC or the pending flag is set.
REQ-010 Port ovf, output, 1 bit: sticky overrun flag, set when an ld is dropped.

Function
REQ-011 The block SHALL have two states: IDLE and CALC.
REQ-012 The block SHALL keep working registers x and y (WIDTH bits), a one-entry hold register (ha, hb), and a pending flag.
REQ-013 In IDLE with ld=1, the next edge SHALL load x=a, y=b and enter CALC; that edge is E0.
REQ-014 Each CALC cycle SHALL perform exactly one step, chosen in this priority order:
- x==0: result is y, done.
- y==0: result is x, done.
- x==y: result is x, done.
- x>y: x := x-y.
- otherwise: y := y-x.
REQ-015 On the done edge, q SHALL take the result and rdy SHALL be 1 for exactly the following cycle.
REQ-016 Latency: rdy is high after edge E0+N, where N is the number of CALC steps including the final one; N=1 for a zero operand or equal operands.
REQ-017 An ld in CALC with pending=0 SHALL capture a and b into ha and hb and set pending=1.
REQ-018 An ld in CALC with pending=1 SHALL be dropped and SHALL set ovf=1; the hold contents are unchanged.
REQ-019 On the done edge, the next operand source SHALL be selected as follows:
- pending=1: ha and hb load into x and y, pending clears, state stays CALC.
- pending=0 and ld=1: a and b load directly, state stays CALC.
- otherwise: state goes to IDLE.
REQ-020 Done with pending=1 and ld=1 in the same cycle: the hold contents start and the new ld is captured into hold, so pending stays 1 and nothing is dropped.
REQ-021 Results SHALL be produced in ld order; no result is lost or reordered.
REQ-022 All arithmetic is unsigned WIDTH-bit; subtraction never underflows by construction.

Reset
REQ-023 With reset=1 at an edge, the block SHALL go to IDLE with q=0, rdy=0, busy=0, ovf=0, pending=0, x=y=0, ha=hb=0.
REQ-024 Reset SHALL take priority over ld and abort any in-flight or pending computation with no rdy pulse.
REQ-025 ld asserted in the same cycle as reset SHALL be ignored.

Configuration
REQ-026 With macro GCD_BINARY_EN defined, CALC SHALL use Stein's algorithm with a shift counter k (reset to 0 at each load).
REQ-027 Stein step priority: zero operand (result is the other operand shifted left by k) > x==y (result x<<k) > both even (both >>1, k+1) > x even (x>>1) > y even (y>>1) > both odd (larger := larger-smaller).
REQ-028 Without GCD_BINARY_EN, the subtractive algorithm of REQ-014 is used and no k register exists.
REQ-029 The handshake, pending, ovf and reset behaviour SHALL be identical in both builds.

Verification
REQ-030 Reset held for 3 cycles -> q=0, rdy=0, busy=0, ovf=0; ld during reset produces no rdy.
REQ-031 WIDTH=8, ld a=12 b=8 -> q=4 and rdy high after E0+3; busy high from E0 until the done edge.
REQ-032 ld a=0 b=9 -> q=9 after E0+1; ld a=5 b=5 -> q=5 after E0+1; ld a=0 b=0 -> q=0 after E0+1.
REQ-033 ld (12,8), then ld (21,14) one cycle later -> pending set; rdy pulses give q=4 then q=7 in order; a third ld while pending -> ovf=1 and exactly two rdy pulses occur.
REQ-034 WIDTH=16, ld a=65535 b=255 -> q=255 after E0+257; reset asserted at E0+100 -> no rdy and the block returns to IDLE.
REQ-035 GCD_BINARY_EN defined, ld a=12 b=8 -> q=4 after E0+6; 100 random pairs match a reference GCD model in both builds.

Source files
------------

// File: rtl/gcd_param_if.sv
// Operand/result handshake bundle for gcd_param: master drives operands and ld,
// slave returns the result, the rdy pulse and the busy/overrun status.
interface gcd_param_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ld;
    logic [WIDTH-1:0] q;
    logic             rdy;
    logic             busy;
    logic             ovf;

    modport master (
        output a, b, ld,
        input  q, rdy, busy, ovf
    );

    modport slave (
        input  a, b, ld,
        output q, rdy, busy, ovf
    );
endinterface

// File: rtl/gcd_param.sv
// gcd_param: iterative GCD engine (one step per cycle) with a one-entry operand hold buffer.
// Defining GCD_BINARY_EN selects Stein's binary algorithm instead of repeated subtraction.
module gcd_param #(
    parameter int unsigned WIDTH = 8
) (
    input logic        clk,
    input logic        reset,
    gcd_param_if.slave bus
);
    typedef enum logic [0:0] {StIdle, StCalc} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] x_q, x_d, y_q, y_d;
    logic [WIDTH-1:0] ha_q, ha_d, hb_q, hb_d;
    logic             pend_q, pend_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             rdy_q, rdy_d;
    logic             ovf_q, ovf_d;

    logic             done;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] x_step, y_step;

`ifdef GCD_BINARY_EN
    localparam int unsigned KW = $clog2(WIDTH) + 1;
    logic [KW-1:0] k_q, k_d, k_step;

    // Common factors of two are stripped into k and restored on completion.
    always_comb begin
        done   = 1'b0;
        result = '0;
        x_step = x_q;
        y_step = y_q;
        k_step = k_q;
        if (x_q == '0) begin
            done   = 1'b1;
            result = y_q << k_q;
        end else if (y_q == '0) begin
            done   = 1'b1;
            result = x_q << k_q;
        end else if (x_q == y_q) begin
            done   = 1'b1;
            result = x_q << k_q;
        end else if (!x_q[0] && !y_q[0]) begin
            x_step = x_q >> 1;
            y_step = y_q >> 1;
            k_step = k_q + KW'(1);
        end else if (!x_q[0]) begin
            x_step = x_q >> 1;
        end else if (!y_q[0]) begin
            y_step = y_q >> 1;
        end else if (x_q > y_q) begin
            x_step = x_q - y_q;
        end else begin
            y_step = y_q - x_q;
        end
    end
`else
    always_comb begin
        done   = 1'b0;
        result = '0;
        x_step = x_q;
        y_step = y_q;
        if (x_q == '0) begin
            done   = 1'b1;
            result = y_q;
        end else if (y_q == '0) begin
            done   = 1'b1;
            result = x_q;
        end else if (x_q == y_q) begin
            done   = 1'b1;
            result = x_q;
        end else if (x_q > y_q) begin
            x_step = x_q - y_q;
        end else begin
            y_step = y_q - x_q;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        ha_d    = ha_q;
        hb_d    = hb_q;
        pend_d  = pend_q;
        q_d     = q_q;
        rdy_d   = 1'b0;
        ovf_d   = ovf_q;
`ifdef GCD_BINARY_EN
        k_d     = k_q;
`endif
        case (state_q)
            StIdle: begin
                if (bus.ld) begin
                    x_d     = bus.a;
                    y_d     = bus.b;
                    state_d = StCalc;
`ifdef GCD_BINARY_EN
                    k_d     = '0;
`endif
                end
            end
            StCalc: begin
                x_d = x_step;
                y_d = y_step;
`ifdef GCD_BINARY_EN
                k_d = k_step;
`endif
                if (done) begin
                    q_d   = result;
                    rdy_d = 1'b1;
                    if (pend_q) begin
                        // Held pair starts; a simultaneous ld refills the hold slot.
                        x_d    = ha_q;
                        y_d    = hb_q;
                        pend_d = 1'b0;
`ifdef GCD_BINARY_EN
                        k_d    = '0;
`endif
                        if (bus.ld) begin
                            ha_d   = bus.a;
                            hb_d   = bus.b;
                            pend_d = 1'b1;
                        end
                    end else if (bus.ld) begin
                        x_d = bus.a;
                        y_d = bus.b;
`ifdef GCD_BINARY_EN
                        k_d = '0;
`endif
                    end else begin
                        state_d = StIdle;
                    end
                end else if (bus.ld) begin
                    if (pend_q) begin
                        ovf_d = 1'b1;
                    end else begin
                        ha_d   = bus.a;
                        hb_d   = bus.b;
                        pend_d = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            x_q     <= '0;
            y_q     <= '0;
            ha_q    <= '0;
            hb_q    <= '0;
            pend_q  <= 1'b0;
            q_q     <= '0;
            rdy_q   <= 1'b0;
            ovf_q   <= 1'b0;
`ifdef GCD_BINARY_EN
            k_q     <= '0;
`endif
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            ha_q    <= ha_d;
            hb_q    <= hb_d;
            pend_q  <= pend_d;
            q_q     <= q_d;
            rdy_q   <= rdy_d;
            ovf_q   <= ovf_d;
`ifdef GCD_BINARY_EN
            k_q     <= k_d;
`endif
        end
    end

    assign bus.q    = q_q;
    assign bus.rdy  = rdy_q;
    assign bus.ovf  = ovf_q;
    assign bus.busy = (state_q == StCalc) || pend_q;

endmodule

// File: tb/tb_gcd_param.sv
// Self-checking bench for gcd_param: table-driven latency/result vectors, hold/overrun
// sequences, random pairs against a Euclid reference, and a 16-bit long run with abort.
module tb_gcd_param;
`ifdef GCD_BINARY_EN
    localparam bit Binary = 1'b1;
`else
    localparam bit Binary = 1'b0;
`endif
    localparam int N12x8   = Binary ? 6 : 3;
    localparam int N16     = Binary ? 10 : 257;
    localparam int AbortAt = Binary ? 5 : 100;

    logic clk;
    logic rst8;
    logic rst16;

    gcd_param_if #(.WIDTH(8))  bus8 ();
    gcd_param_if #(.WIDTH(16)) bus16 ();

    gcd_param #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .reset (rst8),
        .bus   (bus8)
    );

    gcd_param #(.WIDTH(16)) dut16 (
        .clk   (clk),
        .reset (rst16),
        .bus   (bus16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int rdy_cnt8 = 0;
    int unsigned expq[$];

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        int unsigned q;
        int unsigned n_sub;
        int unsigned n_bin;
    } vec_t;
    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    function automatic int unsigned gcd_ref(input int unsigned a, input int unsigned b);
        int unsigned t;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every rdy pulse of the 8-bit DUT consumes the oldest expected result.
    always @(negedge clk) begin
        if (bus8.rdy) begin
            rdy_cnt8++;
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected_rdy: got rdy with q=%0d, required no rdy", bus8.q);
            end else begin
                check("sb_q", 32'(bus8.q), expq.pop_front());
            end
        end
    end

    task automatic run8(input logic [7:0] a, input logic [7:0] b, input int unsigned exp_q,
                        input int exp_n, input bit chk_n, input string nm);
        int  n;
        bit  seen;
        bit  busy_bad;
        expq.push_back(exp_q);
        bus8.a  = a;
        bus8.b  = b;
        bus8.ld = 1'b1;
        tick();
        bus8.ld  = 1'b0;
        n        = 0;
        seen     = 1'b0;
        busy_bad = 1'b0;
        if (!bus8.busy) busy_bad = 1'b1;
        while (!seen && n < 400) begin
            tick();
            n++;
            if (bus8.rdy) seen = 1'b1;
            else if (!bus8.busy) busy_bad = 1'b1;
        end
        if (chk_n) check({nm, "_latency"}, n, exp_n);
        check({nm, "_rdy_seen"}, 32'(seen), 1);
        check({nm, "_busy_during"}, 32'(busy_bad), 0);
        check({nm, "_q"}, 32'(bus8.q), exp_q);
        check({nm, "_busy_after"}, 32'(bus8.busy), 0);
        tick();
        check({nm, "_rdy_pulse_width"}, 32'(bus8.rdy), 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int rc0;
        int n;
        int seen16;
        logic [7:0] ra;
        logic [7:0] rb;

        vecs[0] = '{8'd12,  8'd8,  4,  3,   6};
        vecs[1] = '{8'd0,   8'd9,  9,  1,   1};
        vecs[2] = '{8'd5,   8'd5,  5,  1,   1};
        vecs[3] = '{8'd0,   8'd0,  0,  1,   1};
        vecs[4] = '{8'd9,   8'd0,  9,  1,   1};
        vecs[5] = '{8'd7,   8'd3,  1,  5,   6};
        vecs[6] = '{8'd48,  8'd18, 6,  5,   7};
        vecs[7] = '{8'd128, 8'd64, 64, 2,   8};
        vecs[8] = '{8'd255, 8'd1,  1,  255, 15};

        bus8.a = '0; bus8.b = '0; bus8.ld = 1'b0;
        bus16.a = '0; bus16.b = '0; bus16.ld = 1'b0;

        // Reset for three cycles with ld held high: ld must be ignored.
        rst8 = 1'b1;
        rst16 = 1'b1;
        @(negedge clk);
        bus8.a = 8'd3; bus8.b = 8'd6; bus8.ld = 1'b1;
        repeat (3) tick();
        check("rst_q", 32'(bus8.q), 0);
        check("rst_rdy", 32'(bus8.rdy), 0);
        check("rst_busy", 32'(bus8.busy), 0);
        check("rst_ovf", 32'(bus8.ovf), 0);
        check("rst16_busy", 32'(bus16.busy), 0);
        rst8 = 1'b0;
        rst16 = 1'b0;
        bus8.ld = 1'b0;
        repeat (3) tick();
        check("rst_no_rdy", rdy_cnt8, 0);
        check("rst_idle_busy", 32'(bus8.busy), 0);

        foreach (vecs[i]) begin
            run8(vecs[i].a, vecs[i].b, vecs[i].q,
                 Binary ? vecs[i].n_bin : vecs[i].n_sub, 1'b1, $sformatf("vec%0d", i));
        end

        // Second ld captured into hold, third ld overruns; exactly two results in order.
        rc0 = rdy_cnt8;
        expq.push_back(4);
        expq.push_back(7);
        bus8.a = 8'd12; bus8.b = 8'd8; bus8.ld = 1'b1;
        tick();
        bus8.a = 8'd21; bus8.b = 8'd14;
        tick();
        check("pend_busy", 32'(bus8.busy), 1);
        check("pend_no_ovf_yet", 32'(bus8.ovf), 0);
        bus8.a = 8'd1; bus8.b = 8'd1;
        tick();
        bus8.ld = 1'b0;
        check("ovf_set", 32'(bus8.ovf), 1);
        repeat (40) tick();
        check("ovf_two_pulses", rdy_cnt8 - rc0, 2);
        check("ovf_sticky", 32'(bus8.ovf), 1);
        check("ovf_idle_busy", 32'(bus8.busy), 0);

        rst8 = 1'b1;
        tick();
        rst8 = 1'b0;
        check("rst2_ovf", 32'(bus8.ovf), 0);
        check("rst2_q", 32'(bus8.q), 0);

        // Done with pending=1 and ld=1 together: hold starts, new pair refills the hold.
        rc0 = rdy_cnt8;
        expq.push_back(4);
        expq.push_back(3);
        expq.push_back(2);
        bus8.a = 8'd12; bus8.b = 8'd8; bus8.ld = 1'b1;
        tick();
        bus8.a = 8'd9; bus8.b = 8'd6;
        tick();
        bus8.ld = 1'b0;
        repeat (N12x8 - 2) tick();
        bus8.a = 8'd10; bus8.b = 8'd4; bus8.ld = 1'b1;
        tick();
        bus8.ld = 1'b0;
        check("swap_first_rdy", 32'(bus8.rdy), 1);
        check("swap_first_q", 32'(bus8.q), 4);
        check("swap_busy", 32'(bus8.busy), 1);
        repeat (60) tick();
        check("swap_three_pulses", rdy_cnt8 - rc0, 3);
        check("swap_no_ovf", 32'(bus8.ovf), 0);
        check("swap_idle", 32'(bus8.busy), 0);

        // Done with pending=0 and ld=1: new pair loads directly, back-to-back rdy pulses.
        expq.push_back(5);
        expq.push_back(7);
        bus8.a = 8'd5; bus8.b = 8'd5; bus8.ld = 1'b1;
        tick();
        bus8.a = 8'd0; bus8.b = 8'd7;
        tick();
        bus8.ld = 1'b0;
        check("direct_rdy1", 32'(bus8.rdy), 1);
        check("direct_q1", 32'(bus8.q), 5);
        tick();
        check("direct_rdy2", 32'(bus8.rdy), 1);
        check("direct_q2", 32'(bus8.q), 7);
        tick();
        check("direct_rdy_low", 32'(bus8.rdy), 0);

        for (int i = 0; i < 100; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            run8(ra, rb, gcd_ref(ra, rb), 0, 1'b0, $sformatf("rnd%0d", i));
        end
        check("sb_drained", expq.size(), 0);

        // 16-bit long run.
        bus16.a = 16'd65535; bus16.b = 16'd255; bus16.ld = 1'b1;
        tick();
        bus16.ld = 1'b0;
        n = 0;
        while (!bus16.rdy && n < 1000) begin
            tick();
            n++;
        end
        check("w16_latency", n, N16);
        check("w16_q", 32'(bus16.q), 255);
        tick();

        // Reset mid-computation aborts without a rdy pulse.
        seen16 = 0;
        bus16.a = 16'd65535; bus16.b = 16'd255; bus16.ld = 1'b1;
        tick();
        bus16.ld = 1'b0;
        repeat (AbortAt - 1) begin
            tick();
            if (bus16.rdy) seen16++;
        end
        rst16 = 1'b1;
        bus16.ld = 1'b1;
        tick();
        rst16 = 1'b0;
        bus16.ld = 1'b0;
        check("abort_busy", 32'(bus16.busy), 0);
        check("abort_q", 32'(bus16.q), 0);
        check("abort_rdy", 32'(bus16.rdy), 0);
        repeat (300) begin
            tick();
            if (bus16.rdy) seen16++;
        end
        check("abort_no_rdy", seen16, 0);
        check("abort_idle", 32'(bus16.busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
